// File: rtl/cpu_test_pkg.sv
// Shared types for the CPU test-bench scoreboards: checker FSM states and
// the default-width expected-trace entry.
package cpu_test_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TMO
  } state_e;

  typedef struct packed {
    logic [DEF_REG_AW-1:0] rg;
    logic [DEF_DATA_W-1:0] data;
  } trace_entry_t;
endpackage

// File: rtl/wb_trace_checker_trace_buf.sv
// Append-only expected-trace store with asynchronous read, tail counter and
// full flag. clear empties it; contents are not reset, only the tail.
module trace_buf #(
  parameter  int DEPTH = 64,
  parameter  int EW    = 37,
  localparam int TW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [EW-1:0] push_entry,
  input  logic [PW-1:0] rd_idx,
  output logic [EW-1:0] rd_entry,
  output logic [TW-1:0] tail,
  output logic          full
);
  logic [EW-1:0] mem [DEPTH];

  assign full     = (tail == TW'(DEPTH));
  assign rd_entry = mem[rd_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                tail <= '0;
    else if (clear)          tail <= '0;
    else if (push && !full)  tail <= tail + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (!clear && push && !full) mem[tail[PW-1:0]] <= push_entry;
  end
endmodule

// File: rtl/wb_trace_checker.sv
// Event-ordered register write-back scoreboard: compares qualifying writes
// against a preloaded (reg, value) trace and holds a pass/fail/timeout verdict.
module wb_trace_checker
  import cpu_test_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int REG_AW  = 5,
  parameter  int DEPTH   = 64,
  parameter  int TIMEOUT = 1024,
  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int TW      = $clog2(DEPTH + 1),
  localparam int MW      = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [REG_AW-1:0] ld_reg,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              watch_en,
  input  logic [REG_AW-1:0] watch_reg,
  input  logic              start,
  input  logic              clear,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [PW-1:0]     fail_idx,
  output logic [REG_AW-1:0] fail_reg,
  output logic [DATA_W-1:0] fail_data
);
  typedef struct packed {
    logic [REG_AW-1:0] rg;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e        state;
  logic [PW-1:0] rd_ptr;
  logic [MW-1:0] timer;
  logic [TW-1:0] tail;
  logic          full;
  entry_t        ld_entry, exp_entry;
  logic          ld_fire, wb_hit, wb_match, last;

  assign ld_entry = '{rg: ld_reg, data: ld_data};
  assign ld_ready = (state == ST_IDLE) && !full;
  assign ld_fire  = ld_valid && ld_ready && !clear;

  trace_buf #(.DEPTH(DEPTH), .EW($bits(entry_t))) u_buf (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .push       (ld_fire),
    .push_entry (ld_entry),
    .rd_idx     (rd_ptr),
    .rd_entry   (exp_entry),
    .tail       (tail),
    .full       (full)
  );

  // r0 writes are architectural no-ops and never consume a trace entry
  assign wb_hit   = wb_we && (wb_waddr != '0) && (!watch_en || wb_waddr == watch_reg);
  assign wb_match = (exp_entry.rg == wb_waddr) && (exp_entry.data == wb_wdata);
  assign last     = (TW'(rd_ptr) + TW'(1) == tail);

  assign busy    = (state == ST_RUN);
  assign pass    = (state == ST_PASS);
  assign fail    = (state == ST_FAIL);
  assign timeout = (state == ST_TMO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      rd_ptr    <= '0;
      timer     <= '0;
      fail_idx  <= '0;
      fail_reg  <= '0;
      fail_data <= '0;
    end else if (clear) begin
      state     <= ST_IDLE;
      rd_ptr    <= '0;
      timer     <= '0;
      fail_idx  <= '0;
      fail_reg  <= '0;
      fail_data <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          rd_ptr <= '0;
          timer  <= '0;
          // an append accepted in the start cycle still belongs to the trace
          state  <= (tail != '0 || ld_fire) ? ST_RUN : ST_PASS;
        end
        ST_RUN: begin
          if (wb_hit && wb_match) begin
            timer <= '0;
            if (last) state  <= ST_PASS;
            else      rd_ptr <= rd_ptr + PW'(1);
          end else if (wb_hit) begin
            state     <= ST_FAIL;
            fail_idx  <= rd_ptr;
            fail_reg  <= wb_waddr;
            fail_data <= wb_wdata;
          end else if (timer == MW'(TIMEOUT - 1)) begin
            state <= ST_TMO;
          end else if (timer != '1) begin
            timer <= timer + MW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed self-checking bench for wb_trace_checker (DEPTH=8, TIMEOUT=16).
module tb_wb_trace_checker;
  localparam int DATA_W = 32, REG_AW = 5, DEPTH = 8, TIMEOUT = 16;

  logic              clk = 1'b0, rst = 1'b0;
  logic              wb_we = 1'b0, ld_valid = 1'b0, watch_en = 1'b0, start = 1'b0, clear = 1'b0;
  logic [REG_AW-1:0] wb_waddr = '0, ld_reg = '0, watch_reg = '0;
  logic [DATA_W-1:0] wb_wdata = '0, ld_data = '0;
  logic              ld_ready, busy, pass, fail, timeout;
  logic [2:0]        fail_idx;
  logic [REG_AW-1:0] fail_reg;
  logic [DATA_W-1:0] fail_data;
  int checks = 0, errors = 0;

  wb_trace_checker #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
    .watch_en(watch_en), .watch_reg(watch_reg), .start(start), .clear(clear),
    .busy(busy), .pass(pass), .fail(fail), .timeout(timeout),
    .fail_idx(fail_idx), .fail_reg(fail_reg), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask

  task automatic load(input logic [REG_AW-1:0] r, input logic [DATA_W-1:0] d);
    ld_valid = 1'b1; ld_reg = r; ld_data = d; step(); ld_valid = 1'b0;
  endtask

  task automatic wb(input logic [REG_AW-1:0] r, input logic [DATA_W-1:0] d);
    wb_we = 1'b1; wb_waddr = r; wb_wdata = d; step(); wb_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if ({busy, pass, fail, timeout} !== 4'b0000) begin errors++; $display("FAIL reset_verdict: got %b exp 0000", {busy, pass, fail, timeout}); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_ld_ready: got %b exp 1", ld_ready); end
    checks++; if ({fail_idx, fail_reg, fail_data} !== '0) begin errors++; $display("FAIL reset_fail_info: got %h exp 0", {fail_idx, fail_reg, fail_data}); end
    #9 rst = 1'b1;
    step();
  endtask

  task automatic test_countdown_fail();
    logic [DATA_W-1:0] v [8] = '{5, 4, 3, 2, 1, 0, 1, 2};
    do_clear(); watch_en = 1'b0;
    for (int i = 0; i < 8; i++) load(5'd1, v[i]);
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cd_busy: got %b exp 1", busy); end
    wb(5'd1, 5);
    wb(5'd2, 99);
    checks++; if (fail !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL cd_fail: fail %b busy %b exp 1 0", fail, busy); end
    checks++; if (fail_idx !== 3'd1 || fail_reg !== 5'd2 || fail_data !== 32'd99) begin
      errors++; $display("FAIL cd_fail_info: idx %0d reg %0d data %0d exp 1 2 99", fail_idx, fail_reg, fail_data); end
  endtask

  task automatic test_countdown_pass();
    logic [DATA_W-1:0] v [8] = '{5, 4, 3, 2, 1, 0, 1, 2};
    do_clear(); watch_en = 1'b1; watch_reg = 5'd1;
    for (int i = 0; i < 8; i++) load(5'd1, v[i]);
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      checks++; if (busy !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL cdp_run_%0d: busy %b pass %b exp 1 0", i, busy, pass); end
      wb(5'd2, 32'd1000 + i);
      wb(5'd1, v[i]);
    end
    checks++; if (pass !== 1'b1 || busy !== 1'b0 || fail !== 1'b0) begin
      errors++; $display("FAIL cdp_pass: pass %b busy %b fail %b exp 1 0 0", pass, busy, fail); end
    watch_en = 1'b0;
  endtask

  task automatic test_mismatch();
    do_clear();
    load(5'd1, 5); load(5'd1, 4); load(5'd1, 3);
    pulse_start();
    wb(5'd1, 5); wb(5'd1, 4); wb(5'd1, 7);
    checks++; if (fail !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL mm_verdict: fail %b pass %b exp 1 0", fail, pass); end
    checks++; if (fail_idx !== 3'd2 || fail_reg !== 5'd1 || fail_data !== 32'd7) begin
      errors++; $display("FAIL mm_info: idx %0d reg %0d data %0d exp 2 1 7", fail_idx, fail_reg, fail_data); end
    wb(5'd1, 3); step(); step();
    checks++; if (fail !== 1'b1 || fail_data !== 32'd7 || fail_idx !== 3'd2) begin
      errors++; $display("FAIL mm_sticky: fail %b data %0d idx %0d exp 1 7 2", fail, fail_data, fail_idx); end
  endtask

  task automatic test_timeout();
    do_clear();
    load(5'd3, 32'hAA);
    pulse_start();
    for (int i = 0; i < 15; i++) step();
    checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_early: timeout %b busy %b exp 0 1", timeout, busy); end
    step();
    checks++; if (timeout !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL tmo_fire: timeout %b busy %b exp 1 0", timeout, busy); end
    wb(5'd3, 32'hAA);
    checks++; if (timeout !== 1'b1 || pass !== 1'b0 || fail !== 1'b0) begin
      errors++; $display("FAIL tmo_sticky: timeout %b pass %b fail %b exp 1 0 0", timeout, pass, fail); end
  endtask

  task automatic test_boundaries();
    // r0 write with wrong data must not be checked
    do_clear();
    load(5'd1, 5);
    pulse_start();
    wb(5'd0, 123);
    checks++; if (fail !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL r0_ignored: fail %b busy %b exp 0 1", fail, busy); end
    wb(5'd1, 5);
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL r0_then_pass: got %b exp 1", pass); end
    // empty trace
    do_clear();
    pulse_start();
    checks++; if (pass !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL empty_pass: pass %b busy %b exp 1 0", pass, busy); end
    // append in the start cycle is part of the trace
    do_clear();
    ld_valid = 1'b1; ld_reg = 5'd4; ld_data = 32'h55; start = 1'b1;
    step();
    ld_valid = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL start_append: busy %b pass %b exp 1 0", busy, pass); end
    wb(5'd4, 32'h55);
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL start_append_pass: got %b exp 1", pass); end
    // overflow: 9th append dropped
    do_clear();
    for (int i = 0; i < DEPTH; i++) load(5'd6, i);
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b exp 0", ld_ready); end
    load(5'd6, 32'hDEAD);
    checks++; if (dut.tail !== 4'd8) begin errors++; $display("FAIL full_tail: got %0d exp 8", dut.tail); end
    pulse_start();
    for (int i = 0; i < DEPTH; i++) wb(5'd6, i);
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL full_pass: got %b exp 1", pass); end
  endtask

  task automatic test_clear_priority();
    do_clear();
    load(5'd1, 10); load(5'd1, 11);
    pulse_start();
    wb(5'd1, 10);
    clear = 1'b1; start = 1'b1; ld_valid = 1'b1; ld_reg = 5'd1; ld_data = 9;
    wb_we = 1'b1; wb_waddr = 5'd1; wb_wdata = 11;
    step();
    clear = 1'b0; start = 1'b0; ld_valid = 1'b0; wb_we = 1'b0;
    checks++; if ({busy, pass, fail, timeout} !== 4'b0000 || ld_ready !== 1'b1) begin
      errors++; $display("FAIL clr_state: bpft %b ready %b exp 0000 1", {busy, pass, fail, timeout}, ld_ready); end
    checks++; if (dut.tail !== 4'd0) begin errors++; $display("FAIL clr_tail: got %0d exp 0", dut.tail); end
  endtask

  task automatic test_async_reset();
    do_clear();
    load(5'd1, 5); load(5'd1, 6);
    pulse_start();
    wb(5'd1, 9);
    checks++; if (fail !== 1'b1 || fail_data !== 32'd9) begin errors++; $display("FAIL ar_pre: fail %b data %0d exp 1 9", fail, fail_data); end
    do_clear();
    load(5'd1, 5); load(5'd1, 6);
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ar_busy: got %b exp 1", busy); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({busy, pass, fail, timeout} !== 4'b0000 || ld_ready !== 1'b1 || {fail_idx, fail_reg, fail_data} !== '0) begin
      errors++; $display("FAIL ar_zero: bpft %b ready %b info %h exp 0000 1 0", {busy, pass, fail, timeout}, ld_ready, {fail_idx, fail_reg, fail_data}); end
    checks++; if (dut.tail !== 4'd0) begin errors++; $display("FAIL ar_tail: got %0d exp 0", dut.tail); end
    #1 rst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_countdown_fail();
    test_countdown_pass();
    test_mismatch();
    test_timeout();
    test_boundaries();
    test_clear_priority();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
